led_hint_driver: RTL

Registered LED output stage for the note-game front panel. It replaces the fixed 8-LED driver with a parametrised one and adds:

- a real blink timebase, so the next-note hint blinks at a visible rate;
- an end-of-song sweep animation;
- a fully defined mode/difficulty LED decode.

It sits between the game controller (state, difficulty, reminder, next_reminder, isEnd) and the board LED pins.

---
 rtl/led_hint_if.sv | 24 ++
 rtl/led_hint_driver.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/led_hint_if.sv
// Game-controller to LED-driver bundle: controller status in, LED patterns out.
interface led_hint_if #(
    parameter int unsigned KEYS = 8
);
    logic [2:0]      state;
    logic [2:0]      difficulty;
    logic [KEYS-1:0] reminder;
    logic [KEYS-1:0] next_reminder;
    logic            isEnd;
    logic [KEYS-1:0] key_led;
    logic [7:0]      mode_led;

    // Controller side: drives game status, observes LEDs
    modport master (
        output state, difficulty, reminder, next_reminder, isEnd,
        input  key_led, mode_led
    );

    // LED driver side
    modport slave (
        input  state, difficulty, reminder, next_reminder, isEnd,
        output key_led, mode_led
    );
endinterface

// File: rtl/led_hint_driver.sv
// Registered LED stage: blinking next-note hint, end-of-song sweep, mode decode.
module led_hint_driver #(
    parameter int unsigned KEYS         = 8,
    parameter int unsigned BLINK_DIV    = 25_000_000,
    parameter int unsigned SWEEP_DIV    = 10_000_000,
    parameter int unsigned SWEEP_ROUNDS = 3
) (
    input  logic          clk,
    input  logic          rst,
    led_hint_if.slave     bus
);

    localparam int unsigned BLINK_W = $clog2(BLINK_DIV);
    localparam int unsigned SWEEP_W = $clog2(SWEEP_DIV);
    localparam int unsigned POS_W   = (KEYS > 1) ? $clog2(KEYS) : 1;
    localparam int unsigned ROUND_W = $clog2(SWEEP_ROUNDS + 1);

    localparam logic [2:0] ST_WAIT      = 3'b000;
    localparam logic [2:0] ST_FREEPLAY  = 3'b100;
    localparam logic [2:0] ST_AUTOPLAY  = 3'b010;
    localparam logic [2:0] ST_STUDY     = 3'b001;
    localparam logic [2:0] ST_SELECT    = 3'b111;
    localparam logic [2:0] ST_CHALLENGE = 3'b101;

    localparam logic [2:0] DIFF_EASY   = 3'b100;
    localparam logic [2:0] DIFF_NORMAL = 3'b010;
    localparam logic [2:0] DIFF_HARD   = 3'b001;

    typedef enum logic [1:0] {
        FSM_NORMAL = 2'd0,
        FSM_SWEEP  = 2'd1,
        FSM_DONE   = 2'd2
    } fsm_t;

    fsm_t              fsm_q, fsm_d;
    logic [2:0]        state_q, state_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic              phase_q, phase_d;
    logic [SWEEP_W-1:0] sweep_cnt_q, sweep_cnt_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [KEYS-1:0]   key_led_q, key_led_d;
    logic [7:0]        mode_led_q, mode_led_d;

    logic              state_chg_c;
    logic              phase_cur_c;
    logic [BLINK_W-1:0] blink_base_c;
    logic [KEYS-1:0]   hint_c;
    logic [2:0]        diff_c;

    assign bus.key_led  = key_led_q;
    assign bus.mode_led = mode_led_q;

    // Blink timebase; a state change makes this cycle count 0 of phase 0
    always_comb begin
        state_d      = bus.state;
        state_chg_c  = (bus.state != state_q);
        blink_base_c = state_chg_c ? '0 : blink_cnt_q;
        phase_cur_c  = state_chg_c ? 1'b0 : phase_q;
        if (blink_base_c == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_cur_c;
        end else begin
            blink_cnt_d = blink_base_c + BLINK_W'(1);
            phase_d     = phase_cur_c;
        end
    end

    // Hint pattern: add the next note during phase 1 of study/challenge
    always_comb begin
        hint_c = bus.reminder;
        if ((bus.state == ST_STUDY || bus.state == ST_CHALLENGE) && phase_cur_c &&
            (bus.next_reminder != bus.reminder)) begin
            hint_c = bus.reminder | bus.next_reminder;
        end
    end

    // Key LED FSM: normal hint display, sweep animation, solid done
    always_comb begin
        fsm_d       = fsm_q;
        sweep_cnt_d = sweep_cnt_q;
        pos_d       = pos_q;
        round_d     = round_q;
        key_led_d   = key_led_q;
        case (fsm_q)
            FSM_NORMAL: begin
                if (bus.isEnd) begin
                    fsm_d       = FSM_SWEEP;
                    sweep_cnt_d = '0;
                    pos_d       = '0;
                    round_d     = '0;
                    key_led_d   = KEYS'(1);
                end else begin
                    key_led_d   = hint_c;
                end
            end
            FSM_SWEEP: begin
                if (!bus.isEnd) begin
                    fsm_d     = FSM_NORMAL;
                    key_led_d = hint_c;
                end else if (sweep_cnt_q == SWEEP_W'(SWEEP_DIV - 1)) begin
                    sweep_cnt_d = '0;
                    if (pos_q == POS_W'(KEYS - 1)) begin
                        round_d = round_q + ROUND_W'(1);
                        if (round_q == ROUND_W'(SWEEP_ROUNDS - 1)) begin
                            fsm_d     = FSM_DONE;
                            key_led_d = '1;
                        end else begin
                            pos_d     = '0;
                            key_led_d = KEYS'(1);
                        end
                    end else begin
                        pos_d     = pos_q + POS_W'(1);
                        key_led_d = KEYS'(1) << (pos_q + POS_W'(1));
                    end
                end else begin
                    sweep_cnt_d = sweep_cnt_q + SWEEP_W'(1);
                end
            end
            FSM_DONE: begin
                if (!bus.isEnd) begin
                    fsm_d     = FSM_NORMAL;
                    key_led_d = hint_c;
                end else begin
                    key_led_d = '1;
                end
            end
            default: begin
                fsm_d     = FSM_NORMAL;
                key_led_d = '0;
            end
        endcase
    end

    // Mode/difficulty LED decode with EASY fallback for malformed difficulty
    always_comb begin
        diff_c = DIFF_EASY;
        if (bus.difficulty == DIFF_EASY || bus.difficulty == DIFF_NORMAL ||
            bus.difficulty == DIFF_HARD) begin
            diff_c = bus.difficulty;
        end
        case (bus.state)
            ST_WAIT:      mode_led_d = 8'h00;
            ST_FREEPLAY:  mode_led_d = 8'h80;
            ST_AUTOPLAY:  mode_led_d = 8'h40;
            ST_STUDY:     mode_led_d = 8'h20;
            ST_CHALLENGE: mode_led_d = {5'b00010, diff_c};
            ST_SELECT:    mode_led_d = {5'b01110, diff_c};
            default:      mode_led_d = 8'hF8;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= FSM_NORMAL;
            state_q     <= ST_WAIT;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            sweep_cnt_q <= '0;
            pos_q       <= '0;
            round_q     <= '0;
            key_led_q   <= '0;
            mode_led_q  <= '0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            sweep_cnt_q <= sweep_cnt_d;
            pos_q       <= pos_d;
            round_q     <= round_d;
            key_led_q   <= key_led_d;
            mode_led_q  <= mode_led_d;
        end
    end

endmodule
